// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory: 1-cycle registered fetch, word load port,
// NOP self-clear after reset. Optional fault checking via INSTR_MEM_FAULT_EN.
module instr_mem_sync #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 256,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h00000013)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              fetch_fault,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              init_busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  load_idx;
  logic              fetch_bad;
  logic              load_ok;
  logic              accept;
  logic              unused_bits;

  assign fetch_idx = fetch_addr[IDX_W+1:2];
  assign load_idx  = load_addr[IDX_W+1:2];

`ifdef INSTR_MEM_FAULT_EN
  // Out of range means any address bit above the word index is set.
  assign fetch_bad = (|fetch_addr[1:0]) || (|fetch_addr[ADDR_W-1:IDX_W+2]);
  assign load_ok   = ~(|load_addr[ADDR_W-1:IDX_W+2]);
`else
  assign fetch_bad = 1'b0;
  assign load_ok   = 1'b1;
`endif

  // Address bits outside the index are deliberately ignored in some builds.
  assign unused_bits = ^{fetch_addr, load_addr};

  // Handshake: a fetch is accepted on a rising edge where fetch_req and
  // fetch_ready are both high; its word appears with instr_valid one cycle later.
  assign fetch_ready = (state == S_READY);
  assign init_busy   = (state == S_INIT);
  assign accept      = fetch_req && fetch_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_INIT;
      cnt         <= '0;
      instr_valid <= 1'b0;
      instruction <= NOP_WORD;
      fetch_fault <= 1'b0;
    end else begin
      instr_valid <= accept;
      fetch_fault <= accept && fetch_bad;
      if (accept) begin
        instruction <= fetch_bad ? NOP_WORD : mem[fetch_idx];
      end
      if (state == S_INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH - 1)) begin
          state <= S_READY;
        end
      end
    end
  end

  // Clear has priority over loads; the fetch read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_INIT) begin
        mem[cnt] <= NOP_WORD;
      end else if (load_we && load_ok) begin
        mem[load_idx] <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync with a word-array reference model.
// Build with INSTR_MEM_FAULT_EN defined to exercise the fault variant.
module tb_instr_mem_sync;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 256;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] NOP    = 32'h00000013;
`ifdef INSTR_MEM_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_ready;
  logic              instr_valid;
  logic [DATA_W-1:0] instruction;
  logic              fetch_fault;
  logic              load_we = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic              init_busy;

  instr_mem_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instruction(instruction), .fetch_fault(fetch_fault),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .init_busy(init_busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  logic              fault_q[$];
  int                init_left;
  logic              last_acc;
  logic [DATA_W-1:0] last_instr;
  int                checks = 0;
  int                passes = 0;

  function automatic bit addr_faults(input logic [ADDR_W-1:0] a);
    return FAULT_EN && ((a % 4) != 0 || a >= DEPTH * 4);
  endfunction

  function automatic int word_of(input logic [ADDR_W-1:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // ---------------- drivers ----------------
  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
    init_left  = DEPTH;
    last_acc   = 1'b0;
    last_instr = NOP;
    exp_q.delete();
    fault_q.delete();
  endtask

  task automatic drive_cycle(input logic req, input logic [ADDR_W-1:0] faddr,
                             input logic we, input logic [ADDR_W-1:0] laddr,
                             input logic [DATA_W-1:0] ldata);
    logic [DATA_W-1:0] w;
    bit ready;
    ready      = (init_left == 0);
    fetch_req  = req;
    fetch_addr = faddr;
    load_we    = we;
    load_addr  = laddr;
    load_data  = ldata;
    last_acc   = req && ready;
    if (last_acc) begin
      w = addr_faults(faddr) ? NOP : ref_mem[word_of(faddr)];
      exp_q.push_back(w);
      fault_q.push_back(addr_faults(faddr));
      last_instr = w;
    end
    if (ready && we && !(FAULT_EN && laddr >= DEPTH * 4)) ref_mem[word_of(laddr)] = ldata;
    @(posedge clk);
    @(negedge clk);
    if (init_left > 0) init_left--;
    fetch_req = 1'b0;
    load_we   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int cyc;
    apply_reset(2);
    checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", instr_valid); else passes++;
    checks++; if (instruction !== NOP) $display("FAIL reset_instr got=%h exp=%h", instruction, NOP); else passes++;
    checks++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault got=%b exp=0", fetch_fault); else passes++;
    checks++; if (fetch_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", fetch_ready); else passes++;
    checks++; if (init_busy !== 1'b1) $display("FAIL reset_busy got=%b exp=1", init_busy); else passes++;
    reset = 1'b0;
    // Partway into the clear, restart it with another reset.
    repeat (50) drive_cycle(1'b1, $urandom_range(0, DEPTH * 4 - 1), 1'b1, $urandom_range(0, DEPTH * 4 - 1), $urandom);
    apply_reset(1);
    reset = 1'b0;
    cyc = 0;
    while (init_busy === 1'b1 && cyc < DEPTH + 16) begin
      checks++; if (fetch_ready !== 1'b0 || instr_valid !== 1'b0)
        $display("FAIL init_quiet cycle=%0d ready=%b valid=%b exp=0/0", cyc, fetch_ready, instr_valid);
      else passes++;
      drive_cycle($urandom_range(0, 1), $urandom_range(0, DEPTH * 4 - 1), $urandom_range(0, 1),
                  $urandom_range(0, DEPTH * 4 - 1) & ~32'h3, $urandom);
      cyc++;
    end
    checks++; if (cyc !== DEPTH) $display("FAIL init_length got=%0d exp=%0d", cyc, DEPTH); else passes++;
    checks++; if (fetch_ready !== 1'b1) $display("FAIL ready_after_init got=%b exp=1", fetch_ready); else passes++;
  endtask

  task automatic test_nop_fill;
    logic [ADDR_W-1:0] addrs [3];
    logic [DATA_W-1:0] e;
    addrs = '{32'h0, 32'h4, 32'h3FC};
    foreach (addrs[i]) begin
      drive_cycle(1'b1, addrs[i], 1'b0, '0, '0);
      e = exp_q.pop_front(); void'(fault_q.pop_front());
      checks++; if (instr_valid !== 1'b1) $display("FAIL fill_valid addr=%h got=%b exp=1", addrs[i], instr_valid); else passes++;
      checks++; if (instruction !== e || e !== NOP) $display("FAIL fill_word addr=%h got=%h exp=%h", addrs[i], instruction, NOP); else passes++;
    end
  endtask

  task automatic test_back_to_back;
    logic [ADDR_W-1:0] addrs [3];
    logic [DATA_W-1:0] e;
    drive_cycle(1'b0, '0, 1'b1, 32'h4, 32'h00500093);
    drive_cycle(1'b0, '0, 1'b1, 32'h8, 32'h00A00113);
    checks++; if (instr_valid !== 1'b0) $display("FAIL load_only_valid got=%b exp=0", instr_valid); else passes++;
    addrs = '{32'h4, 32'h8, 32'h0};
    foreach (addrs[i]) begin
      drive_cycle(1'b1, addrs[i], 1'b0, '0, '0);
      e = exp_q.pop_front(); void'(fault_q.pop_front());
      checks++; if (instr_valid !== 1'b1) $display("FAIL b2b_valid addr=%h got=%b exp=1", addrs[i], instr_valid); else passes++;
      checks++; if (instruction !== e) $display("FAIL b2b_word addr=%h got=%h exp=%h", addrs[i], instruction, e); else passes++;
    end
  endtask

  task automatic test_same_cycle;
    logic [DATA_W-1:0] e;
    drive_cycle(1'b1, 32'h10, 1'b1, 32'h10, 32'hDEADBEEF);
    e = exp_q.pop_front(); void'(fault_q.pop_front());
    checks++; if (instruction !== e || e !== NOP) $display("FAIL rbw_old got=%h exp=%h", instruction, NOP); else passes++;
    // Next-cycle read sees the new word; also load a different index concurrently.
    drive_cycle(1'b1, 32'h10, 1'b1, 32'h20, 32'hCAFEF00D);
    e = exp_q.pop_front(); void'(fault_q.pop_front());
    checks++; if (instruction !== e || e !== 32'hDEADBEEF) $display("FAIL rbw_new got=%h exp=%h", instruction, 32'hDEADBEEF); else passes++;
    drive_cycle(1'b1, 32'h20, 1'b0, '0, '0);
    e = exp_q.pop_front(); void'(fault_q.pop_front());
    checks++; if (instruction !== e) $display("FAIL diff_idx got=%h exp=%h", instruction, e); else passes++;
  endtask

  task automatic test_idle_hold;
    drive_cycle(1'b1, 32'h4, 1'b0, '0, '0);
    void'(exp_q.pop_front()); void'(fault_q.pop_front());
    repeat (3) begin
      drive_cycle(1'b0, $urandom, 1'b0, '0, '0);
      checks++; if (instr_valid !== 1'b0) $display("FAIL idle_valid got=%b exp=0", instr_valid); else passes++;
      checks++; if (instruction !== last_instr) $display("FAIL idle_hold got=%h exp=%h", instruction, last_instr); else passes++;
    end
  endtask

  task automatic test_random;
    logic [DATA_W-1:0] e;
    logic f;
    logic [ADDR_W-1:0] fa, la;
    for (int i = 0; i < 400; i++) begin
      fa = ($urandom_range(0, 3) != 0) ? ADDR_W'($urandom_range(0, DEPTH - 1) * 4)
                                       : ADDR_W'($urandom_range(0, DEPTH * 8 - 1));
      la = ADDR_W'($urandom_range(0, DEPTH * 8 - 1));
      drive_cycle($urandom_range(0, 3) != 0, fa, $urandom_range(0, 1), la, $urandom);
      checks++; if (instr_valid !== last_acc) $display("FAIL rand_valid i=%0d got=%b exp=%b", i, instr_valid, last_acc); else passes++;
      if (last_acc) begin
        e = exp_q.pop_front(); f = fault_q.pop_front();
        checks++; if (instruction !== e) $display("FAIL rand_word i=%0d addr=%h got=%h exp=%h", i, fa, instruction, e); else passes++;
        checks++; if (fetch_fault !== f) $display("FAIL rand_fault i=%0d addr=%h got=%b exp=%b", i, fa, fetch_fault, f); else passes++;
      end
    end
  endtask

  task automatic test_fault;
    logic [ADDR_W-1:0] addrs [3];
    logic [DATA_W-1:0] e;
    logic f;
    drive_cycle(1'b0, '0, 1'b1, 32'h0, 32'h12345678);
    drive_cycle(1'b0, '0, 1'b1, 32'h404, 32'h0BADC0DE);
    addrs = '{32'h2, 32'h400, 32'h4};
    foreach (addrs[i]) begin
      drive_cycle(1'b1, addrs[i], 1'b0, '0, '0);
      e = exp_q.pop_front(); f = fault_q.pop_front();
      checks++; if (instruction !== e) $display("FAIL fault_word addr=%h got=%h exp=%h", addrs[i], instruction, e); else passes++;
      checks++; if (fetch_fault !== f) $display("FAIL fault_flag addr=%h got=%b exp=%b", addrs[i], fetch_fault, f); else passes++;
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [DATA_W-1:0] e;
    drive_cycle(1'b1, 32'h10, 1'b0, '0, '0);
    drive_cycle(1'b1, 32'h14, 1'b0, '0, '0);
    exp_q.delete(); fault_q.delete();
    fetch_req  = 1'b1;
    fetch_addr = 32'h18;
    apply_reset(1);
    fetch_req = 1'b0;
    checks++; if (instr_valid !== 1'b0) $display("FAIL midreset_valid got=%b exp=0", instr_valid); else passes++;
    checks++; if (init_busy !== 1'b1) $display("FAIL midreset_busy got=%b exp=1", init_busy); else passes++;
    reset = 1'b0;
    cyc = 0;
    while (init_busy === 1'b1 && cyc < DEPTH + 16) begin
      drive_cycle(1'b1, 32'h10, 1'b0, '0, '0);
      cyc++;
    end
    checks++; if (cyc !== DEPTH) $display("FAIL midreset_init_len got=%0d exp=%0d", cyc, DEPTH); else passes++;
    drive_cycle(1'b1, 32'h10, 1'b0, '0, '0);
    e = exp_q.pop_front(); void'(fault_q.pop_front());
    checks++; if (instruction !== e || e !== NOP) $display("FAIL midreset_cleared got=%h exp=%h", instruction, NOP); else passes++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_nop_fill();
    test_back_to_back();
    test_same_cycle();
    test_idle_hold();
    test_fault();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
